// File: rtl/uart_report_pkg.sv
// Shared constants, state type and digit encoder for the hex telemetry reporter.
package uart_report_pkg;

  localparam logic [7:0] CH_V  = 8'h56;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return CH_0 + {4'd0, n};
    else           return CH_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_reporter_if.sv
// Byte stream handshake between the reporter and the UART transmitter.
interface uart_hex_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_hex_reporter_tick_timer.sv
// Free-running period timer; one-cycle tick on each wrap to 0. PERIOD_CYCLES=0 disables it.
module tick_timer #(
  parameter int PERIOD_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic wrap;

  generate
    if (PERIOD_CYCLES == 0) begin : g_off
      assign wrap = 1'b0;
    end else begin : g_on
      localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
      logic [CW-1:0] cnt;

      assign wrap = (cnt == LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + CW'(1);
      end
    end
  endgenerate

  // Registered so the tick coincides with the counter sitting at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= wrap;
  end

endmodule

// File: rtl/uart_hex_reporter.sv
// Snapshots value_in on trig or timer tick and streams "V=<hex>\r\n" to the UART byte input.
module uart_hex_reporter
  import uart_report_pkg::*;
#(
  parameter int VALUE_W       = 16,
  parameter int PERIOD_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               trig,
  uart_hex_reporter_if.master tx,
  output logic               busy,
  output logic               overrun
);

  localparam int NDIG   = VALUE_W / 4;
  localparam int NBYTES = NDIG + 4;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  function automatic logic [7:0] msg_byte(input logic [IW-1:0] k, input logic [VALUE_W-1:0] s);
    int ki;
    logic [VALUE_W-1:0] sh;
    ki = int'(k);
    sh = s >> (4 * (NDIG + 1 - ki));
    if (ki == 0)               return CH_V;
    else if (ki == 1)          return CH_EQ;
    else if (ki == NBYTES - 2) return CH_CR;
    else if (ki == NBYTES - 1) return CH_LF;
    else                       return nib2ascii(sh[3:0]);
  endfunction

  state_t             state, state_n;
  logic [IW-1:0]      idx, idx_n;
  logic [VALUE_W-1:0] snap, snap_n;
  logic [7:0]         data_q, data_n;
  logic               valid_q, valid_n;
  logic               busy_n, pending, pending_n, overrun_n;
  logic               tick, req, xfer;

  tick_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign req         = trig | tick;
  assign xfer        = valid_q & tx.tx_ready;
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      snap    <= snap_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      busy    <= busy_n;
      pending <= pending_n;
      overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    snap_n    = snap;
    data_n    = data_q;
    valid_n   = valid_q;
    busy_n    = busy;
    pending_n = pending;
    overrun_n = overrun;
    unique case (state)
      IDLE: begin
        if (req || pending) begin
          state_n   = SEND;
          snap_n    = value_in;
          // A fresh request landing while a queued one starts becomes the new pending.
          pending_n = pending & req;
          idx_n     = '0;
          data_n    = CH_V;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end
      end
      SEND: begin
        if (req) begin
          if (!pending) pending_n = 1'b1;
          else          overrun_n = 1'b1;
        end
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
          end else begin
            idx_n  = idx + IW'(1);
            data_n = msg_byte(idx + IW'(1), snap);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Scoreboard bench: stimulus pushes hand-computed bytes, negedge monitors pop and compare.
module tb_uart_hex_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst1, trig, trig1;
  logic [15:0] value_in, value1;
  logic        busy, overrun, busy1, overrun1;
  logic        rdy0 = 1'b1;
  int          rdy_mode = 0;
  int          checks = 0, errors = 0;
  int          cyc1;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp1_q[$];
  int          rise_q[$];

  uart_hex_reporter_if bus0();
  uart_hex_reporter_if bus1();

  assign bus0.tx_ready = rdy0;
  assign bus1.tx_ready = 1'b1;

  uart_hex_reporter #(.VALUE_W(16), .PERIOD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .value_in(value_in), .trig(trig),
    .tx(bus0), .busy(busy), .overrun(overrun)
  );

  uart_hex_reporter #(.VALUE_W(16), .PERIOD_CYCLES(50)) dut1 (
    .clk(clk), .rst(rst1), .value_in(value1), .trig(trig1),
    .tx(bus1), .busy(busy1), .overrun(overrun1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [63:0] line, input bit to1);
    logic [63:0] l;
    l = line;
    for (int i = 7; i >= 0; i--) begin
      if (to1) exp1_q.push_back(l[i*8 +: 8]);
      else     exp_q.push_back(l[i*8 +: 8]);
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    check("idle_timeout_busy", busy, 0);
  endtask

  // Ready pattern: 0 = always ready, 1 = ~30% ready, other = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy0 = 1'b1;
      1:       rdy0 = ($urandom_range(0, 9) < 3);
      default: rdy0 = 1'b0;
    endcase
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus0.tx_valid, 1);
        check("stall_data", bus0.tx_data, prev_data);
      end
      if (bus0.tx_valid && bus0.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte0: got %0h expected none", bus0.tx_data);
        end else begin
          check("byte0", bus0.tx_data, exp_q.pop_front());
        end
      end
      prev_stall = bus0.tx_valid && !bus0.tx_ready;
      prev_data  = bus0.tx_data;
    end
  end

  always @(posedge clk) begin
    if (rst1) cyc1 <= 0;
    else      cyc1 <= cyc1 + 1;
  end

  logic prev_v1 = 1'b0;

  always @(negedge clk) begin
    if (rst1) begin
      prev_v1 = 1'b0;
    end else begin
      if (bus1.tx_valid && !prev_v1) begin
        if (rise_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rise1: got cycle %0d expected none", cyc1);
        end else begin
          check("rise_cycle1", cyc1, rise_q.pop_front());
        end
      end
      if (bus1.tx_valid) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte1: got %0h expected none", bus1.tx_data);
        end else begin
          check("byte1", bus1.tx_data, exp1_q.pop_front());
        end
      end
      prev_v1 = bus1.tx_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; rst1 = 1'b1; trig = 1'b0; trig1 = 1'b0;
    value_in = 16'h0000; value1 = 16'h3C07;
    #1;
    check("rst_valid", bus0.tx_valid, 0);
    check("rst_data", bus0.tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Back-to-back line, 1-cycle latency.
    value_in = 16'hBEEF;
    push8(64'h56_3D_42_45_45_46_0D_0A, 1'b0);
    trig = 1'b1;
    check("t1_valid_before", bus0.tx_valid, 0);
    step();
    trig = 1'b0;
    check("t1_latency_valid", bus0.tx_valid, 1);
    check("t1_busy", busy, 1);
    wait_idle(20, n);
    check("t1_cycles", n, 8);
    check("t1_valid_after", bus0.tx_valid, 0);
    check("t1_overrun", overrun, 0);
    step(); step();

    // Random backpressure; monitor checks stall stability.
    value_in = 16'h09A0;
    push8(64'h56_3D_30_39_41_30_0D_0A, 1'b0);
    rdy_mode = 1;
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_idle(400, n);
    rdy_mode = 0;
    check("t2_queue_empty", exp_q.size(), 0);
    step(); step();

    // Snapshot immune to later value_in changes.
    value_in = 16'h1234;
    push8(64'h56_3D_31_32_33_34_0D_0A, 1'b0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    value_in = 16'hFFFF;
    wait_idle(20, n);
    check("t3_queue_empty", exp_q.size(), 0);
    step(); step();

    // Pending then overrun.
    value_in = 16'hA5C3;
    push8(64'h56_3D_41_35_43_33_0D_0A, 1'b0);
    push8(64'h56_3D_37_45_30_31_0D_0A, 1'b0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    value_in = 16'h7E01;
    step();
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("t4_overrun_after_2nd", overrun, 0);
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("t4_overrun_after_3rd", overrun, 1);
    wait_idle(20, n);
    check("t4_gap_valid", bus0.tx_valid, 0);
    step();
    check("t4_restart_valid", bus0.tx_valid, 1);
    wait_idle(20, n);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_overrun_sticky", overrun, 1);
    step(); step();

    // Asynchronous reset mid-line.
    value_in = 16'h0F3B;
    push8(64'h56_3D_30_46_33_42_0D_0A, 1'b0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", bus0.tx_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_bytes_left", exp_q.size(), 5);
    exp_q.delete();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("t6_quiet_valid", bus0.tx_valid, 0);
    check("t6_quiet_busy", busy, 0);
    check("t6_overrun_cleared", overrun, 0);
    push8(64'h56_3D_30_46_33_42_0D_0A, 1'b0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_idle(20, n);
    check("t6_queue_empty", exp_q.size(), 0);

    // Timer-driven reports on the second instance.
    rise_q.push_back(51);
    rise_q.push_back(101);
    rise_q.push_back(151);
    push8(64'h56_3D_33_43_30_37_0D_0A, 1'b1);
    push8(64'h56_3D_33_43_30_37_0D_0A, 1'b1);
    push8(64'h56_3D_33_43_30_37_0D_0A, 1'b1);
    rst1 = 1'b0;
    for (int i = 0; i < 165; i++) step();
    check("t5_rises_left", rise_q.size(), 0);
    check("t5_bytes_left", exp1_q.size(), 0);
    check("t5_overrun", overrun1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
